biquad8_coeff_loader: RTL and testbench

BIQUAD8_COEFF_LOADER -- requirements
Module: biquad8_coeff_loader

---
 rtl/biquad8_pkg.sv | 27 ++
 rtl/biquad8_coeff_shadow.sv | 78 +++++++
 rtl/biquad8_coeff_loader.sv | 147 ++++++++++++++
 tb/tb_biquad8_coeff_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad8_pkg.sv
// Shared definitions for the biquad8 coefficient loader: loader state
// encoding, shadow address map bases and chain-tail write addresses.
package biquad8_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_F = 3'd1,
        LOAD_G = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int unsigned ADR_BITS = 5;
    localparam int unsigned F_BASE   = 0;
    localparam int unsigned G_BASE   = 16;

    // Tail addresses of the default-length chains (FLEN=8, GLEN=9).
    localparam logic [ADR_BITS-1:0] F_TAIL_ADR = 5'h07;
    localparam logic [ADR_BITS-1:0] G_TAIL_ADR = 5'h18;

    // Address of the last DSP in a chain starting at base with len taps.
    function automatic logic [ADR_BITS-1:0] tail_adr(input int unsigned base,
                                                     input int unsigned len);
        return ADR_BITS'(base + len - 1);
    endfunction

endpackage

// File: rtl/biquad8_coeff_shadow.sv
// Shadow coefficient store: F entries at F_BASE.., G entries at G_BASE..
// One write port, one registered read port with write-first forwarding,
// and (with BIQUAD8_COEFF_READBACK_EN) a registered readback port.
// Contents are deliberately not reset.
module biquad8_coeff_shadow
    import biquad8_pkg::*;
#(
    parameter int unsigned COEFF_BITS = 18,
    parameter int unsigned FLEN       = 8,
    parameter int unsigned GLEN       = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [4:0]            wr_adr,
    input  logic [COEFF_BITS-1:0] wr_dat,
    input  logic [4:0]            rd_adr,
    output logic [COEFF_BITS-1:0] rd_dat
`ifdef BIQUAD8_COEFF_READBACK_EN
    ,
    input  logic [4:0]            rb_adr,
    output logic [COEFF_BITS-1:0] rb_dat
`endif
);

    logic [COEFF_BITS-1:0] f_mem [FLEN];
    logic [COEFF_BITS-1:0] g_mem [GLEN];
    logic [COEFF_BITS-1:0] rd_val;

    // Write the addressed entry; unmapped addresses match nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < FLEN; k++) begin
                if (wr_adr == ADR_BITS'(F_BASE + k)) f_mem[k] <= wr_dat;
            end
            for (int unsigned k = 0; k < GLEN; k++) begin
                if (wr_adr == ADR_BITS'(G_BASE + k)) g_mem[k] <= wr_dat;
            end
        end
    end

    // Read mux for the transfer port; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < FLEN; k++) begin
            if (rd_adr == ADR_BITS'(F_BASE + k)) rd_val = f_mem[k];
        end
        for (int unsigned k = 0; k < GLEN; k++) begin
            if (rd_adr == ADR_BITS'(G_BASE + k)) rd_val = g_mem[k];
        end
    end

    // Registered read; a same-edge write to the read address is forwarded
    // so a write issued together with commit reaches the transfer.
    always_ff @(posedge clk) begin
        rd_dat <= (wr_en && (wr_adr == rd_adr)) ? wr_dat : rd_val;
    end

`ifdef BIQUAD8_COEFF_READBACK_EN
    logic [COEFF_BITS-1:0] rb_val;

    // Readback mux; unmapped addresses read as zero.
    always_comb begin
        rb_val = '0;
        for (int unsigned k = 0; k < FLEN; k++) begin
            if (rb_adr == ADR_BITS'(F_BASE + k)) rb_val = f_mem[k];
        end
        for (int unsigned k = 0; k < GLEN; k++) begin
            if (rb_adr == ADR_BITS'(G_BASE + k)) rb_val = g_mem[k];
        end
    end

    // Readback register: stored value one cycle after the address.
    always_ff @(posedge clk) begin
        rb_dat <= rb_val;
    end
`endif

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Coefficient loader for the pole FIR: software fills a shadow store,
// commit streams F then G (tail entry first) into the B-cascades at the
// chain-tail addresses, then pulses coeff_update_o and done_o.
// Optional readback port: define BIQUAD8_COEFF_READBACK_EN.
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int unsigned COEFF_BITS = 18,
    parameter int unsigned FLEN       = 8,
    parameter int unsigned GLEN       = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            cfg_adr_i,
    input  logic [COEFF_BITS-1:0] cfg_dat_i,
    input  logic                  cfg_wr_i,
    input  logic                  commit_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  err_clr_i,
    output logic [4:0]            coeff_adr_o,
    output logic                  coeff_wr_o,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_update_o
`ifdef BIQUAD8_COEFF_READBACK_EN
    ,
    input  logic [4:0]            rd_adr_i,
    output logic [COEFF_BITS-1:0] rd_dat_o
`endif
);

    localparam logic [4:0] F_TAIL = tail_adr(F_BASE, FLEN);
    localparam logic [4:0] G_TAIL = tail_adr(G_BASE, GLEN);

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [4:0]            shd_rd_adr;
    logic [COEFF_BITS-1:0] shd_rd_dat;
    logic                  shd_wr_en;

    assign shd_wr_en = cfg_wr_i && (state_q == IDLE);

    biquad8_coeff_shadow #(
        .COEFF_BITS (COEFF_BITS),
        .FLEN       (FLEN),
        .GLEN       (GLEN)
    ) u_shadow (
        .clk    (clk),
        .wr_en  (shd_wr_en),
        .wr_adr (cfg_adr_i),
        .wr_dat (cfg_dat_i),
        .rd_adr (shd_rd_adr),
        .rd_dat (shd_rd_dat)
`ifdef BIQUAD8_COEFF_READBACK_EN
        ,
        .rb_adr (rd_adr_i),
        .rb_dat (rd_dat_o)
`endif
    );

    // State, tap counter and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state and outputs. The shadow read address is taken from the
    // next tap index so the registered read data lines up with the cycle
    // in which that tap is written out.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shd_rd_adr     = '0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        coeff_wr_o     = 1'b0;
        coeff_update_o = 1'b0;
        coeff_adr_o    = '0;
        coeff_dat_o    = '0;

        case (state_q)
            IDLE: begin
                if (commit_i) begin
                    state_d    = LOAD_F;
                    cnt_d      = 5'(FLEN - 1);
                    shd_rd_adr = F_TAIL;
                end
            end
            LOAD_F: begin
                busy_o      = 1'b1;
                coeff_wr_o  = 1'b1;
                coeff_adr_o = F_TAIL;
                coeff_dat_o = shd_rd_dat;
                if (cnt_q == '0) begin
                    state_d    = LOAD_G;
                    cnt_d      = 5'(GLEN - 1);
                    shd_rd_adr = G_TAIL;
                end else begin
                    cnt_d      = cnt_q - 5'd1;
                    shd_rd_adr = 5'(F_BASE) + cnt_d;
                end
            end
            LOAD_G: begin
                busy_o      = 1'b1;
                coeff_wr_o  = 1'b1;
                coeff_adr_o = G_TAIL;
                coeff_dat_o = shd_rd_dat;
                if (cnt_q == '0) begin
                    state_d = UPDATE;
                end else begin
                    cnt_d      = cnt_q - 5'd1;
                    shd_rd_adr = 5'(G_BASE) + cnt_d;
                end
            end
            UPDATE: begin
                busy_o         = 1'b1;
                coeff_update_o = 1'b1;
                state_d        = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Error: commit outside IDLE, or a write dropped while busy.
        // Clear wins over a simultaneous set.
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end else if (((state_q != IDLE) && commit_i) || (cfg_wr_i && busy_o)) begin
            err_d = 1'b1;
        end
        err_o = err_q;
    end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader: directed scenarios plus
// randomized traffic against a transfer-position reference model and a
// model of the pole FIR B-cascades fed from the coeff_* outputs.
module tb_biquad8_coeff_loader;

    localparam int unsigned CB   = 18;
    localparam int unsigned FL   = 8;
    localparam int unsigned GL   = 9;
    localparam int unsigned XFER = FL + GL + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    cfg_adr_i;
    logic [CB-1:0] cfg_dat_i;
    logic          cfg_wr_i;
    logic          commit_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          err_clr_i;
    logic [4:0]    coeff_adr_o;
    logic          coeff_wr_o;
    logic [CB-1:0] coeff_dat_o;
    logic          coeff_update_o;
`ifdef BIQUAD8_COEFF_READBACK_EN
    logic [4:0]    rd_adr_i;
    logic [CB-1:0] rd_dat_o;
    logic [CB-1:0] rb_exp;
`endif

    always #5 clk = ~clk;

    biquad8_coeff_loader #(
        .COEFF_BITS (CB),
        .FLEN       (FL),
        .GLEN       (GL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_adr_i      (cfg_adr_i),
        .cfg_dat_i      (cfg_dat_i),
        .cfg_wr_i       (cfg_wr_i),
        .commit_i       (commit_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .err_clr_i      (err_clr_i),
        .coeff_adr_o    (coeff_adr_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_update_o (coeff_update_o)
`ifdef BIQUAD8_COEFF_READBACK_EN
        ,
        .rd_adr_i       (rd_adr_i),
        .rd_dat_o       (rd_dat_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: shadow contents, position within a transfer
    // (0 = idle, 1..XFER = cycle number after the commit edge), sticky error.
    logic [CB-1:0] f_m [FL];
    logic [CB-1:0] g_m [GL];
    int unsigned   p_m   = 0;
    logic          err_m = 1'b0;
    logic          rb_en = 1'b0;

    // Pole FIR B-cascades: new data enters DSP 0 and shifts toward the tail.
    logic [CB-1:0] f_dsp [FL];
    logic [CB-1:0] g_dsp [GL];
    int            upd_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CB-1:0] shadow_val(input logic [4:0] a);
        int ai;
        ai = int'(a);
        if (ai < FL) return f_m[ai];
        if (ai >= 16 && ai < 16 + GL) return g_m[ai - 16];
        return '0;
    endfunction

    function automatic logic [63:0] exp_outs(input int unsigned p, input logic e);
        logic          w, u, d, b;
        logic [4:0]    a;
        logic [CB-1:0] v;
        w = (p >= 1) && (p <= FL + GL);
        u = (p == FL + GL + 1);
        d = (p == XFER);
        b = (p >= 1) && (p <= FL + GL + 1);
        a = '0;
        v = '0;
        if (p >= 1 && p <= FL) begin
            a = 5'(FL - 1);
            v = f_m[FL - p];
        end else if (w) begin
            a = 5'(16 + GL - 1);
            v = g_m[GL - (p - FL)];
        end
        return {36'b0, b, d, e, w, u, a, v};
    endfunction

    function automatic logic [63:0] dut_outs();
        return {36'b0, busy_o, done_o, err_o, coeff_wr_o, coeff_update_o, coeff_adr_o, coeff_dat_o};
    endfunction

    // One clock: advance cascade and reference model on the current inputs,
    // then compare every output just after the edge.
    task automatic cyc();
        logic idle, busy_m, set;
        int   ai;
        if (coeff_wr_o === 1'b1) begin
            if (coeff_adr_o == 5'(FL - 1)) begin
                for (int k = FL - 1; k > 0; k--) f_dsp[k] = f_dsp[k - 1];
                f_dsp[0] = coeff_dat_o;
            end else if (coeff_adr_o == 5'(16 + GL - 1)) begin
                for (int k = GL - 1; k > 0; k--) g_dsp[k] = g_dsp[k - 1];
                g_dsp[0] = coeff_dat_o;
            end
        end
        idle   = (p_m == 0);
        busy_m = (p_m >= 1) && (p_m <= FL + GL + 1);
`ifdef BIQUAD8_COEFF_READBACK_EN
        rb_exp = shadow_val(rd_adr_i);
`endif
        set = (!idle && commit_i) || (cfg_wr_i && busy_m);
        if (idle && cfg_wr_i) begin
            ai = int'(cfg_adr_i);
            if (ai < FL) f_m[ai] = cfg_dat_i;
            else if (ai >= 16 && ai < 16 + GL) g_m[ai - 16] = cfg_dat_i;
        end
        if (rst) begin
            p_m   = 0;
            err_m = 1'b0;
        end else begin
            if (err_clr_i) err_m = 1'b0;
            else if (set) err_m = 1'b1;
            if (idle) p_m = commit_i ? 1 : 0;
            else p_m = (p_m == XFER) ? 0 : p_m + 1;
        end
        @(posedge clk);
        #1;
        check("outs", dut_outs(), exp_outs(p_m, err_m));
        if (coeff_update_o === 1'b1) begin
            upd_seen++;
            for (int k = 0; k < FL; k++) check("f_dsp", 64'(f_dsp[k]), 64'(f_m[k]));
            for (int k = 0; k < GL; k++) check("g_dsp", 64'(g_dsp[k]), 64'(g_m[k]));
        end
`ifdef BIQUAD8_COEFF_READBACK_EN
        if (rb_en) check("rdback", 64'(rd_dat_o), 64'(rb_exp));
`endif
    endtask

    task automatic wr_one(input logic [4:0] a, input logic [CB-1:0] d);
        cfg_wr_i  = 1'b1;
        cfg_adr_i = a;
        cfg_dat_i = d;
        cyc();
        cfg_wr_i  = 1'b0;
    endtask

    task automatic run_idle();
        for (int i = 0; i < 40 && p_m != 0; i++) cyc();
        check("idle", 64'(busy_o), 64'(0));
    endtask

    initial begin
        logic [CB-1:0] v;
        int            upd_before;

        rst = 1'b1; cfg_adr_i = '0; cfg_dat_i = '0; cfg_wr_i = 1'b0;
        commit_i = 1'b0; err_clr_i = 1'b0;
`ifdef BIQUAD8_COEFF_READBACK_EN
        rd_adr_i = '0;
`endif
        for (int k = 0; k < FL; k++) begin f_m[k] = '0; f_dsp[k] = '0; end
        for (int k = 0; k < GL; k++) begin g_m[k] = '0; g_dsp[k] = '0; end
        repeat (3) cyc();
        check("reset", dut_outs(), 64'h0);
        rst = 1'b0;

        // Known pattern in the shadow.
        for (int k = 0; k < FL; k++) wr_one(5'(k), CB'(32'h100 + k));
        for (int k = 0; k < GL; k++) wr_one(5'(16 + k), CB'(32'h200 + k));
        rb_en = 1'b1;

        // Full transfer against fixed expectations.
        commit_i = 1'b1; cyc(); commit_i = 1'b0;
        for (int n = 1; n <= XFER; n++) begin
            if (n <= FL) begin
                v = CB'(32'h100 + FL - n);
                check("f_seq", {39'b0, coeff_wr_o, coeff_adr_o, coeff_dat_o}, {39'b0, 1'b1, 5'h07, v});
            end else if (n <= FL + GL) begin
                v = CB'(32'h200 + FL + GL - n);
                check("g_seq", {39'b0, coeff_wr_o, coeff_adr_o, coeff_dat_o}, {39'b0, 1'b1, 5'h18, v});
            end else if (n == FL + GL + 1) begin
                check("upd_cycle", 64'({coeff_update_o, coeff_wr_o, done_o}), 64'(3'b100));
            end else begin
                check("done_cycle", 64'({done_o, busy_o, coeff_update_o}), 64'(3'b100));
            end
            if (n < XFER) cyc();
        end
        cyc();
        for (int k = 0; k < FL; k++) check("f_dsp_pat", 64'(f_dsp[k]), 64'(32'h100 + k));
        for (int k = 0; k < GL; k++) check("g_dsp_pat", 64'(g_dsp[k]), 64'(32'h200 + k));

        // Write during a transfer is dropped and flags an error.
        commit_i = 1'b1; cyc(); commit_i = 1'b0;
        repeat (4) cyc();
        wr_one(5'h00, 18'h3AAAA);
        check("err_set", 64'(err_o), 64'(1));
        run_idle();
        err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
        check("err_clr", 64'(err_o), 64'(0));

        // Reset mid-transfer, then a clean re-commit.
        upd_before = upd_seen;
        commit_i = 1'b1; cyc(); commit_i = 1'b0;
        repeat (9) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check("rst_outs", dut_outs(), 64'h0);
        cyc();
        check("no_upd", 64'(upd_seen), 64'(upd_before));
        commit_i = 1'b1; cyc(); commit_i = 1'b0;
        run_idle();
        check("f0_intact", 64'(f_dsp[0]), 64'(32'h100));
        check("g8_intact", 64'(g_dsp[GL - 1]), 64'(32'h208));

        // Unmapped write with commit: no error.
        commit_i = 1'b1; wr_one(5'h0A, 18'h12345); commit_i = 1'b0;
        check("unmapped_noerr", 64'(err_o), 64'(0));
        run_idle();

        // Write plus commit on the same cycle lands in the transfer.
        commit_i = 1'b1; wr_one(5'h03, 18'h3FFFF); commit_i = 1'b0;
        repeat (4) cyc();
        check("f3_max", 64'(coeff_dat_o), 64'(18'h3FFFF));
        run_idle();

`ifdef BIQUAD8_COEFF_READBACK_EN
        rd_adr_i = 5'h12; cyc();
        check("rb_g2", 64'(rd_dat_o), 64'(32'h202));
        rd_adr_i = 5'h1F; cyc();
        check("rb_unmapped", 64'(rd_dat_o), 64'(0));
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(199) == 0);
            cfg_wr_i  = ($urandom_range(3) == 0);
            case ($urandom_range(2))
                0: cfg_adr_i = 5'($urandom_range(FL - 1));
                1: cfg_adr_i = 5'(16 + $urandom_range(GL - 1));
                default: cfg_adr_i = 5'($urandom);
            endcase
            cfg_dat_i = CB'($urandom);
            commit_i  = ($urandom_range(24) == 0);
            err_clr_i = ($urandom_range(39) == 0);
`ifdef BIQUAD8_COEFF_READBACK_EN
            rd_adr_i  = 5'($urandom);
`endif
            cyc();
        end
        rst = 1'b0; cfg_wr_i = 1'b0; commit_i = 1'b0; err_clr_i = 1'b0;
        run_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
